// File: rtl/mini_src_bus_pkg.sv
// Shared constants for the Mini-SRC datapath bus: source indices, default sizes
// and the index-width helper used by the bus multiplexer and its interface.
package mini_src_bus_pkg;

  localparam int NSRC_DEFAULT  = 24;
  localparam int WIDTH_DEFAULT = 32;

  localparam int SRC_R0     = 0;
  localparam int SRC_R1     = 1;
  localparam int SRC_R2     = 2;
  localparam int SRC_R3     = 3;
  localparam int SRC_R4     = 4;
  localparam int SRC_R5     = 5;
  localparam int SRC_R6     = 6;
  localparam int SRC_R7     = 7;
  localparam int SRC_R8     = 8;
  localparam int SRC_R9     = 9;
  localparam int SRC_R10    = 10;
  localparam int SRC_R11    = 11;
  localparam int SRC_R12    = 12;
  localparam int SRC_R13    = 13;
  localparam int SRC_R14    = 14;
  localparam int SRC_R15    = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHI    = 18;
  localparam int SRC_ZLO    = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_C      = 23;

  // A single-source bus still gets a 1-bit index so no port collapses to zero width.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_mux_reg_if.sv
// Source-side and bus-side signals of the datapath bus multiplexer; the slave
// modport is the multiplexer, the master modport is whoever drives the sources.
interface bus_mux_reg_if
  import mini_src_bus_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int NSRC  = NSRC_DEFAULT,
  parameter int CW    = 8
);
  localparam int IW = idx_width(NSRC);

  logic [NSRC*WIDTH-1:0] src_data;
  logic [NSRC-1:0]       src_out;
  logic                  err_clr;
  logic [WIDTH-1:0]      bus_out;
  logic                  bus_valid;
  logic [IW-1:0]         bus_src;
  logic                  conflict;
  logic                  conflict_sticky;
  logic [CW-1:0]         conflict_count;

  modport master (
    output src_data, src_out, err_clr,
    input  bus_out, bus_valid, bus_src, conflict, conflict_sticky, conflict_count
  );

  modport slave (
    input  src_data, src_out, err_clr,
    output bus_out, bus_valid, bus_src, conflict, conflict_sticky, conflict_count
  );

endinterface

// File: rtl/bus_mux_reg_prio_enc_multi.sv
// Lowest-index-wins priority encoder that also flags more than one request.
module prio_enc_multi
  import mini_src_bus_pkg::*;
#(
  parameter int N = NSRC_DEFAULT
) (
  input  logic [N-1:0]            req,
  output logic [idx_width(N)-1:0] idx,
  output logic                    any,
  output logic                    multi
);
  localparam int IW = idx_width(N);

  always_comb begin
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = IW'(i);
      end
    end
  end

  assign any = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(req & (req - N'(1)));

endmodule

// File: rtl/bus_mux_reg.sv
// Priority-resolved N-source bus driver with optional output register,
// hold-last-value mode and multiple-driver detection.
module bus_mux_reg
  import mini_src_bus_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int NSRC    = NSRC_DEFAULT,
  parameter int REG_OUT = 1,
  parameter int HOLD    = 1,
  parameter int CW      = 8
) (
  input logic         clock,
  input logic         clear,
  bus_mux_reg_if.slave bus
);
  localparam int IW = idx_width(NSRC);

  logic [IW-1:0]    win_idx;
  logic             any;
  logic             multi;
  logic [WIDTH-1:0] sel_data;
  logic             sel_valid;
  logic [IW-1:0]    sel_idx;
  logic [WIDTH-1:0] hold_reg;
  logic             conflict_reg;
  logic             sticky_reg;
  logic [CW-1:0]    count_reg;

  prio_enc_multi #(.N(NSRC)) u_enc (
    .req   (bus.src_out),
    .idx   (win_idx),
    .any   (any),
    .multi (multi)
  );

  // Data is picked only through the winning enable, so undriven sources never leak.
  always_comb begin
    sel_valid = any;
    sel_idx   = any ? win_idx : '0;
    if (any) begin
      sel_data = bus.src_data[int'(win_idx)*WIDTH +: WIDTH];
    end else if (HOLD != 0) begin
      sel_data = hold_reg;
    end else begin
      sel_data = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      hold_reg <= '0;
    end else if (sel_valid) begin
      hold_reg <= sel_data;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      conflict_reg <= 1'b0;
      sticky_reg   <= 1'b0;
      count_reg    <= '0;
    end else begin
      conflict_reg <= multi;
      if (multi) begin
        // An error clear in the same cycle wipes history but still counts this event.
        sticky_reg <= 1'b1;
        if (bus.err_clr) begin
          count_reg <= CW'(1);
        end else if (count_reg != {CW{1'b1}}) begin
          count_reg <= count_reg + CW'(1);
        end
      end else if (bus.err_clr) begin
        sticky_reg <= 1'b0;
        count_reg  <= '0;
      end
    end
  end

  assign bus.conflict        = conflict_reg;
  assign bus.conflict_sticky = sticky_reg;
  assign bus.conflict_count  = count_reg;

  if (REG_OUT != 0) begin : g_reg_out
    logic [WIDTH-1:0] bus_reg;
    logic             valid_reg;
    logic [IW-1:0]    src_reg;

    always_ff @(posedge clock) begin
      if (clear) begin
        bus_reg   <= '0;
        valid_reg <= 1'b0;
        src_reg   <= '0;
      end else begin
        bus_reg   <= sel_data;
        valid_reg <= sel_valid;
        src_reg   <= sel_idx;
      end
    end

    assign bus.bus_out   = bus_reg;
    assign bus.bus_valid = valid_reg;
    assign bus.bus_src   = src_reg;
  end else begin : g_comb_out
    assign bus.bus_out   = clear ? '0 : sel_data;
    assign bus.bus_valid = clear ? 1'b0 : sel_valid;
    assign bus.bus_src   = clear ? '0 : sel_idx;
  end

endmodule

// File: doc/bus_mux_reg.md
Name: bus_mux_reg

Overview:
- Parametrised successor to the datapath bus multiplexer.
- N-source, priority-resolved bus driver for the Mini-SRC datapath, with optional output register and hold-last-value mode.
- Detects multiple simultaneous drivers: per-cycle pulse, sticky flag and saturating counter, so control-unit sequencing errors are observable.
- Sits between the register file / HI / LO / Z / PC / MDR / InPort / C-sign-extend sources and every bus consumer.

Parameters:
- WIDTH, 32, data width of each source and of the bus.
- NSRC, 24, number of sources; index 0 has highest priority.
- REG_OUT, 1, 1 = bus_out registered (latency 1); 0 = bus_out combinational (latency 0).
- HOLD, 1, 1 = when no source is enabled, the bus keeps the last driven value; 0 = the bus drives zero.
- CW, 8, width of the conflict counter.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  reset; synchronous and active-high.
- src_data  in  NSRC*WIDTH  packed source data; source i occupies bits [i*WIDTH +: WIDTH].
- src_out  in  NSRC  per-source drive enables (e.g. R0out..Cout).
- err_clr  in  1  clears conflict_sticky and conflict_count.
- bus_out  out  WIDTH  bus value.
- bus_valid  out  1  a source drove bus_out (aligned with bus_out).
- bus_src  out  $clog2(NSRC)  index of the winning source (aligned with bus_out).
- conflict  out  1  registered pulse: more than one enable was set in the previous cycle.
- conflict_sticky  out  1  set on any conflict; held until err_clr or clear.
- conflict_count  out  CW  number of conflict cycles; saturates at 2^CW-1.

Behaviour:
- Selection: the winner is the lowest index i with src_out[i]=1. Source i is selected only through its own enable, never by value.
- Any enable set: sel_data = src_data[winner], sel_valid = 1, sel_idx = winner.
- No enable set: sel_valid = 0 and sel_idx = 0.
  - HOLD=1: sel_data = hold_q, the last driven value.
  - HOLD=0: sel_data = 0.
- hold_q loads sel_data on every cycle with sel_valid = 1. It is used only when HOLD=1 and exists in both REG_OUT modes.
- REG_OUT=1: bus_out, bus_valid and bus_src register sel_data, sel_valid and sel_idx on each rising edge. Latency is exactly 1 cycle.
- REG_OUT=0: bus_out, bus_valid and bus_src are combinational from the current inputs and hold_q. Latency is 0.
- Conflict: multi = popcount(src_out) > 1. The winner still drives normally; the conflict never corrupts data.
- conflict <= multi every cycle, so it is a 1-cycle registered pulse in both REG_OUT modes.
- Sticky flag and counter:
  - multi=1 and err_clr=0: conflict_sticky <= 1 and conflict_count <= sat_inc(conflict_count).
  - err_clr=1 and multi=0: conflict_sticky <= 0 and conflict_count <= 0.
  - err_clr=1 and multi=1 in the same cycle: the clear applies first, then the new event is counted: conflict_sticky <= 1, conflict_count <= 1.
- Saturation: at 2^CW-1 the count stays put; it never wraps.
- clear (sync, highest priority) forces bus_out=0, bus_valid=0, bus_src=0, hold_q=0, conflict=0, conflict_sticky=0, conflict_count=0. It overrides err_clr and all inputs in that cycle.
- clear mid-operation: in the cycle after clear deasserts, outputs reflect the new inputs normally. With HOLD=1 and no driver, bus_out = 0 because hold_q was cleared.
- NSRC=1: bus_src is 1 bit wide, tied to 0. Conflict never asserts.
- No X-propagation: unused source data never reaches bus_out.

Decomposition:
- Shared package mini_src_bus_pkg holds:
  - Source index constants: SRC_R0=0..SRC_R15=15, SRC_HI=16, SRC_LO=17, SRC_ZHI=18, SRC_ZLO=19, SRC_PC=20, SRC_MDR=21, SRC_INPORT=22, SRC_C=23.
  - NSRC_DEFAULT=24 and WIDTH_DEFAULT=32.
- One sub-module, prio_enc_multi, is natural:
  - Parameter N.
  - Input req[N].
  - Outputs idx [$clog2(N)], any, multi.
  - Purely combinational; instantiated once.

Test Plan:
- Default params, clear for 2 cycles → all outputs 0. Then src_out[SRC_R5]=1 with R5=0xDEADBEEF → next cycle bus_out=0xDEADBEEF, bus_valid=1, bus_src=5, conflict=0.
- src_out[SRC_PC] and src_out[SRC_MDR] both set, PC=0x100, MDR=0x200 → bus_out=0x100, bus_src=20, conflict=1 for exactly 1 cycle, conflict_sticky=1, conflict_count=1.
- HOLD=1: drive R2=0x55, then all enables low for 3 cycles → bus_out stays 0x55 with bus_valid=0. Rerun with HOLD=0 → bus_out=0.
- CW=2: 5 consecutive conflict cycles → conflict_count reads 1, 2, 3, 3, 3; conflict_sticky stays 1.
- err_clr pulsed in a cycle with no conflict → sticky=0, count=0. err_clr in the same cycle as a conflict → sticky=1, count=1.
- REG_OUT=0: R0=0x1 enabled → bus_out=0x1 in the same cycle. clear asserted mid-stream with R0 enabled → on the next edge hold_q, sticky and count read 0, and the following cycle bus_out tracks the inputs again.
